// File: rtl/des_key_schedule_seq.sv
// rtl/des_key_schedule_seq.sv - sequential DES key-schedule controller
//
// Purpose: accepts a 64-bit DES key, applies PC-1, keeps the C/D halves in
// registers and steps an external combinational shifter/PC-2 stage once per
// round. Round keys leave in order on a valid/ready stream.
//
// Optional feature macro: KEY_PARITY_CHECK_EN (odd parity required per key byte).
//
// Ports:
//   clk, rst                   clock (rising edge), asynchronous active-high reset
//   key_load, key_in, mode     key-load request, DES key (bit 63 = DES bit 1), 1=encrypt
//   flush                      synchronous abort to IDLE
//   load_ready                 high in IDLE; key accepted on key_load && load_ready
//   sh_mode, sh_round          latched mode and current round, to shifter stage
//   sh_Ci, sh_Di               C/D registers, to shifter stage
//   sh_Ci_next, sh_Di_next     shifted halves returned by shifter stage
//   sh_key                     PC-2 round key returned by shifter stage
//   rk_data, rk_round          registered round key and its round index
//   rk_valid, rk_ready         round-key stream handshake
//   busy, done, parity_err     status: RUN/DRAIN, end-of-schedule pulse, key rejection pulse

module des_key_schedule_seq #(
  parameter int NUM_ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_load,
  input  logic [63:0] key_in,
  input  logic        mode,
  input  logic        flush,
  output logic        load_ready,
  output logic        sh_mode,
  output logic [3:0]  sh_round,
  output logic [27:0] sh_Ci,
  output logic [27:0] sh_Di,
  input  logic [27:0] sh_Ci_next,
  input  logic [27:0] sh_Di_next,
  input  logic [47:0] sh_key,
  output logic [47:0] rk_data,
  output logic [3:0]  rk_round,
  output logic        rk_valid,
  input  logic        rk_ready,
  output logic        busy,
  output logic        done,
  output logic        parity_err
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

  // PC-1 source positions in DES numbering (1 = MSB of key_in)
  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] res;
    res = '0;
    for (int j = 0; j < 56; j++) begin
      res[55-j] = k[64-PC1_TAB[j]];
    end
    return res;
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [27:0] r_c;
  logic [27:0] r_d;
  logic [3:0]  r_cnt;
  logic        r_mode;
  logic [47:0] r_rk_data;
  logic [3:0]  r_rk_round;
  logic        r_rk_valid;
  logic        r_done;
  logic        r_parity_err;

  logic [55:0] w_pc1;
  logic        w_parity_ok;
  logic        w_accept;
  logic        w_advance;
  logic        w_drain_done;
  logic        w_abort;
  logic        w_parity_rej;

  assign w_pc1 = pc1(key_in);

`ifdef KEY_PARITY_CHECK_EN
  always_comb begin
    w_parity_ok = 1'b1;
    for (int b = 0; b < 8; b++) begin
      w_parity_ok = w_parity_ok & (^key_in[b*8 +: 8]);
    end
  end
`else
  // Parity bits are not part of PC-1; sink them so they are visibly unused.
  logic w_unused_parity;
  assign w_unused_parity = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                             key_in[24], key_in[16], key_in[8],  key_in[0]};
  assign w_parity_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_advance    = 1'b0;
    w_drain_done = 1'b0;
    w_abort      = 1'b0;
    w_parity_rej = 1'b0;
    case (r_state)
      S_IDLE: begin
        // flush wins over a same-cycle load; flush itself is a no-op here
        if (key_load && !flush) begin
          if (w_parity_ok) begin
            w_accept     = 1'b1;
            w_state_next = S_RUN;
          end else begin
            w_parity_rej = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (flush) begin
          w_abort      = 1'b1;
          w_state_next = S_IDLE;
        end else if (!r_rk_valid || rk_ready) begin
          w_advance = 1'b1;
          if (r_cnt == LAST_ROUND) begin
            w_state_next = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (flush) begin
          w_abort      = 1'b1;
          w_state_next = S_IDLE;
        end else if (r_rk_valid && rk_ready) begin
          w_drain_done = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_c          <= '0;
      r_d          <= '0;
      r_cnt        <= '0;
      r_mode       <= 1'b0;
      r_rk_data    <= '0;
      r_rk_round   <= '0;
      r_rk_valid   <= 1'b0;
      r_done       <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_done       <= w_drain_done;
      r_parity_err <= w_parity_rej;
      if (w_abort) begin
        // C/D intentionally hold across an abort
        r_rk_valid <= 1'b0;
        r_cnt      <= '0;
      end else if (w_accept) begin
        r_c    <= w_pc1[55:28];
        r_d    <= w_pc1[27:0];
        r_mode <= mode;
        r_cnt  <= '0;
      end else if (w_advance) begin
        r_rk_data  <= sh_key;
        r_rk_round <= r_cnt;
        r_rk_valid <= 1'b1;
        r_c        <= sh_Ci_next;
        r_d        <= sh_Di_next;
        if (r_cnt != LAST_ROUND) begin
          r_cnt <= r_cnt + 4'd1;
        end
      end else if (w_drain_done) begin
        r_rk_valid <= 1'b0;
      end
    end
  end

  assign load_ready = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign sh_mode    = r_mode;
  assign sh_round   = r_cnt;
  assign sh_Ci      = r_c;
  assign sh_Di      = r_d;
  assign rk_data    = r_rk_data;
  assign rk_round   = r_rk_round;
  assign rk_valid   = r_rk_valid;
  assign done       = r_done;
  assign parity_err = r_parity_err;

endmodule

// File: tb/tb_des_key_schedule_seq.sv
// tb/tb_des_key_schedule_seq.sv - self-checking bench for des_key_schedule_seq

module tb_des_key_schedule_seq;

  logic        clk;
  logic        rst;
  logic        key_load;
  logic [63:0] key_in;
  logic        mode;
  logic        flush;
  logic        load_ready;
  logic        sh_mode;
  logic [3:0]  sh_round;
  logic [27:0] sh_Ci;
  logic [27:0] sh_Di;
  logic [27:0] sh_Ci_next;
  logic [27:0] sh_Di_next;
  logic [47:0] sh_key;
  logic [47:0] rk_data;
  logic [3:0]  rk_round;
  logic        rk_valid;
  logic        rk_ready;
  logic        busy;
  logic        done;
  logic        parity_err;

  int checks = 0;
  int failures = 0;

  localparam logic [63:0] KAT_KEY = 64'h133457799BBCDFF1;
  localparam logic [47:0] KAT_K1  = 48'h1B02EFFC7072;
  localparam logic [47:0] KAT_K16 = 48'hCB3D8B0E17F5;

  localparam int ENC_SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam int DEC_SH [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  des_key_schedule_seq #(.NUM_ROUNDS(16)) dut (
    .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in), .mode(mode),
    .flush(flush), .load_ready(load_ready), .sh_mode(sh_mode), .sh_round(sh_round),
    .sh_Ci(sh_Ci), .sh_Di(sh_Di), .sh_Ci_next(sh_Ci_next), .sh_Di_next(sh_Di_next),
    .sh_key(sh_key), .rk_data(rk_data), .rk_round(rk_round), .rk_valid(rk_valid),
    .rk_ready(rk_ready), .busy(busy), .done(done), .parity_err(parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [27:0] rotl(input logic [27:0] v, input int n);
    logic [55:0] t;
    t = {v, v} << n;
    return t[55:28];
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] v, input int n);
    logic [55:0] t;
    t = {v, v} >> n;
    return t[27:0];
  endfunction

  function automatic logic [55:0] pc1_ref(input logic [63:0] k);
    logic [55:0] r;
    for (int j = 0; j < 56; j++) r[55-j] = k[64-PC1[j]];
    return r;
  endfunction

  function automatic logic [47:0] pc2_ref(input logic [55:0] cd);
    logic [47:0] r;
    for (int j = 0; j < 48; j++) r[47-j] = cd[56-PC2[j]];
    return r;
  endfunction

  // external shifter stage: rotate by this round's amount, then PC-2
  function automatic logic [27:0] stub_shift(input logic [27:0] v, input logic m, input logic [3:0] r);
    return m ? rotl(v, ENC_SH[r]) : rotr(v, DEC_SH[r]);
  endfunction

  assign sh_Ci_next = stub_shift(sh_Ci, sh_mode, sh_round);
  assign sh_Di_next = stub_shift(sh_Di, sh_mode, sh_round);
  assign sh_key     = pc2_ref({sh_Ci_next, sh_Di_next});

  // reference: K_i = PC2 of halves rotated left by the cumulative shift total
  function automatic logic [47:0] ref_round_key(input logic [63:0] key, input logic m, input int r);
    logic [55:0] cd0;
    int k;
    int s;
    cd0 = pc1_ref(key);
    k = m ? r + 1 : 16 - r;
    s = 0;
    for (int i = 0; i < k; i++) s += ENC_SH[i];
    s = s % 28;
    return pc2_ref({rotl(cd0[55:28], s), rotl(cd0[27:0], s)});
  endfunction

  function automatic logic [63:0] fix_parity(input logic [63:0] k);
    logic [63:0] r;
    r = k;
    for (int b = 0; b < 8; b++) r[b*8] = ~(^r[b*8+1 +: 7]);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [63:0] k, input logic m);
    for (int i = 0; i < 50 && !load_ready; i++) step();
    chk("load_ready_wait", load_ready, 1);
    key_in   = k;
    mode     = m;
    key_load = 1'b1;
    step();
    key_load = 1'b0;
    chk("busy_after_load", busy, 1);
  endtask

  task automatic kat(input logic m, input logic [47:0] e0, input logic [47:0] e15);
    load_key(KAT_KEY, m);
    rk_ready = 1'b1;
    step();
    chk("kat_valid0", rk_valid, 1);
    chk("kat_round0", rk_round, 0);
    chk("kat_data0", rk_data, e0);
    repeat (15) step();
    chk("kat_round15", rk_round, 15);
    chk("kat_data15", rk_data, e15);
    step();
    chk("kat_done", done, 1);
    chk("kat_load_ready", load_ready, 1);
    step();
    chk("kat_done_clear", done, 0);
  endtask

  // ready_mode: 0 = always ready, 1 = random ready, 2 = 5-cycle stall at round 3
  task automatic run_sched(input logic [63:0] key, input logic m, input int ready_mode, input bit inject_load);
    int idx = 0;
    int cyc = 0;
    int first_valid = -1;
    int last_hs = -1;
    int stall = 0;
    int dones = 0;
    bit prev_stalled = 0;
    logic [47:0] prev_d = '0;
    logic [3:0] prev_r = '0;
    logic r;
    load_key(key, m);
    while (idx < 16 && cyc < 400) begin
      if (prev_stalled) begin
        chk("bp_data", rk_data, prev_d);
        chk("bp_round", rk_round, prev_r);
      end
      if (rk_valid && first_valid < 0) first_valid = cyc;
      case (ready_mode)
        0: r = 1'b1;
        1: r = 1'($urandom_range(0, 1));
        default: begin
          r = !(rk_valid && rk_round == 4'd3 && stall < 5);
          if (!r) stall++;
        end
      endcase
      rk_ready = r;
      key_load = inject_load && (cyc == 3);
      key_in   = ~key;
      mode     = ~m;
      if (rk_valid && r) begin
        chk("rk_data", rk_data, ref_round_key(key, m, idx));
        chk("rk_round", rk_round, idx);
        idx++;
        last_hs = cyc;
      end
      prev_stalled = rk_valid && !r;
      prev_d = rk_data;
      prev_r = rk_round;
      if (done) dones++;
      step();
      cyc++;
    end
    key_load = 1'b0;
    chk("all_rounds", idx, 16);
    chk("done_pulse", done, 1);
    chk("load_ready_after", load_ready, 1);
    chk("no_early_done", dones, 0);
    step();
    chk("done_clear", done, 0);
    if (ready_mode == 0) begin
      chk("latency", first_valid, 1);
      chk("no_bubble", last_hs - first_valid, 15);
    end
    if (ready_mode == 2) chk("stall_span", last_hs - first_valid, 20);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    key_load = 1'b0;
    key_in = '0;
    mode = 1'b0;
    flush = 1'b0;
    rk_ready = 1'b0;
    #3;
    chk("rst_load_ready", load_ready, 1);
    chk("rst_rk_valid", rk_valid, 0);
    chk("rst_rk_data", rk_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_parity_err", parity_err, 0);
    chk("rst_sh_ci", sh_Ci, 0);
    #10 rst = 1'b0;
    step();

    kat(1'b1, KAT_K1, KAT_K16);
    kat(1'b0, KAT_K16, KAT_K1);

    run_sched(KAT_KEY, 1'b1, 0, 1'b0);
    run_sched(KAT_KEY, 1'b1, 2, 1'b0);
    run_sched(KAT_KEY, 1'b0, 0, 1'b1);

    // flush at round 7
    load_key(KAT_KEY, 1'b1);
    rk_ready = 1'b1;
    for (int i = 0; i < 40 && !(rk_valid && rk_round == 4'd7); i++) step();
    chk("reach_round7", rk_round, 7);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_valid", rk_valid, 0);
    chk("flush_busy", busy, 0);
    chk("flush_load_ready", load_ready, 1);
    chk("flush_done", done, 0);
    step();
    chk("flush_done_later", done, 0);

    // flush and key_load together in IDLE
    key_in = KAT_KEY;
    mode = 1'b1;
    key_load = 1'b1;
    flush = 1'b1;
    step();
    key_load = 1'b0;
    flush = 1'b0;
    chk("flush_load_busy", busy, 0);
    chk("flush_load_ready", load_ready, 1);
    step();
    chk("flush_load_valid", rk_valid, 0);

    // asynchronous reset during round 10
    load_key(KAT_KEY, 1'b1);
    rk_ready = 1'b1;
    for (int i = 0; i < 40 && !(rk_valid && rk_round == 4'd10); i++) step();
    chk("reach_round10", rk_round, 10);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", rk_valid, 0);
    chk("arst_data", rk_data, 0);
    chk("arst_round", rk_round, 0);
    chk("arst_busy", busy, 0);
    chk("arst_load_ready", load_ready, 1);
    chk("arst_sh_round", sh_round, 0);
    chk("arst_sh_mode", sh_mode, 0);
    chk("arst_sh_di", sh_Di, 0);
    #2 rst = 1'b0;
    run_sched(KAT_KEY, 1'b1, 0, 1'b0);

`ifdef KEY_PARITY_CHECK_EN
    key_in = 64'h133457799BBCDFF0;
    mode = 1'b1;
    key_load = 1'b1;
    step();
    key_load = 1'b0;
    chk("par_err_pulse", parity_err, 1);
    chk("par_load_ready", load_ready, 1);
    chk("par_busy", busy, 0);
    step();
    chk("par_err_clear", parity_err, 0);
    chk("par_no_valid", rk_valid, 0);
    run_sched(KAT_KEY, 1'b1, 0, 1'b0);
`else
    key_in = 64'h133457799BBCDFF0;
    mode = 1'b1;
    key_load = 1'b1;
    step();
    key_load = 1'b0;
    chk("nopar_err", parity_err, 0);
    chk("nopar_accepted", busy, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("nopar_flushed", load_ready, 1);
`endif

    for (int t = 0; t < 4; t++) begin
      run_sched(fix_parity({$urandom, $urandom}), 1'($urandom_range(0, 1)), 1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/des_key_schedule_seq.md
Name: des_key_schedule_seq

Overview:
Sequential key-schedule controller for the DES datapath. It accepts a 64-bit key, applies PC-1, and holds the C/D halves in registers. It drives the combinational round-key shifter stage once per round and feeds that stage's Ci_next/Di_next back into its C/D registers. It emits the 16 48-bit round keys in order on a valid/ready stream to the round datapath.

Parameters:
NUM_ROUNDS, 16, rounds per key schedule; the round counter is 4 bits wide, so legal values are 1..16.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
key_load  input  1  key-load request (valid)
key_in  input  64  DES key including parity bits; bit 63 = DES bit 1
mode  input  1  1 = encrypt (left shifts), 0 = decrypt (right shifts); sampled with key_load
flush  input  1  synchronous abort to IDLE
load_ready  output  1  high only in IDLE; key accepted when key_load && load_ready
sh_mode  output  1  latched mode, to the shifter stage
sh_round  output  4  current round index 0..NUM_ROUNDS-1, to the shifter stage
sh_Ci  output  28  C register, to the shifter stage
sh_Di  output  28  D register, to the shifter stage
sh_Ci_next  input  28  shifted C from the shifter stage
sh_Di_next  input  28  shifted D from the shifter stage
sh_key  input  48  PC-2 round key from the shifter stage
rk_data  output  48  registered round key
rk_round  output  4  round index of rk_data
rk_valid  output  1  rk_data valid
rk_ready  input  1  consumer ready
busy  output  1  high in RUN and DRAIN
done  output  1  one-cycle pulse after the final round key is accepted
parity_err  output  1  one-cycle pulse on key rejection (see Optional Feature)

Behaviour:
- Reset (async, rst=1) clears the following to 0: C, D, round counter, mode latch, rk_data, rk_round, rk_valid, busy, done, parity_err. State goes to IDLE; load_ready=1.
- Key acceptance edge: C <= PC-1(key_in)[55:28], D <= PC-1(key_in)[27:0], mode latched, counter <= 0, state -> RUN.
- Combinational outputs: sh_round = counter, sh_mode = mode latch, sh_Ci/sh_Di = C/D registers.
- States:
  - IDLE: load_ready=1, rk_valid=0. Acceptance -> RUN.
  - RUN: advance = !rk_valid || rk_ready. On advance:
    - rk_data <= sh_key, rk_round <= counter, rk_valid <= 1.
    - C <= sh_Ci_next, D <= sh_Di_next.
    - If counter == NUM_ROUNDS-1, go DRAIN; else counter <= counter+1.
    - With no advance, all registers hold.
  - DRAIN: waits for rk_valid && rk_ready. Then rk_valid <= 0, done <= 1 for exactly one cycle, state -> IDLE.
- Latency: key accepted at edge N gives rk_valid=1 after edge N+1 carrying round 0. With rk_ready held high, rounds 0..15 appear on 16 consecutive cycles with no bubbles. load_ready returns high one cycle after the final handshake.
- Backpressure: while rk_valid && !rk_ready, rk_data, rk_round, C, D and counter are stable.
- key_load outside IDLE is ignored; no queuing.
- flush: at the next edge state -> IDLE, rk_valid <= 0, counter <= 0, busy <= 0. C/D hold. done does not pulse.
- flush has priority over key_load in the same cycle; the key is not accepted. A flush while in IDLE has no effect.
- Reset asserted mid-schedule aborts immediately and asynchronously. Outputs go to their reset values.

Optional Feature:
KEY_PARITY_CHECK_EN
- Defined: at the acceptance edge, each key_in byte must have odd parity.
- On any failing byte: the key is not loaded, state stays IDLE, and parity_err pulses high for one cycle.
- Not defined: parity bits are ignored and parity_err is tied to 0.

Test Plan:
- Encrypt, round keys: key 0x133457799BBCDFF1, mode=1, rk_ready=1 -> round 0 rk_data=0x1B02EFFC7072 two edges after load; round 15 = 0xCB3D8B0E17F5; 16 consecutive valids; done pulses once.
- Decrypt order: same key, mode=0 -> round 0 = 0xCB3D8B0E17F5, round 15 = 0x1B02EFFC7072.
- Backpressure: rk_ready low for 5 cycles at round 3 -> rk_data/rk_round frozen at round 3. Resume gives round 4 next, and the full sequence is unchanged.
- flush and load: flush at round 7 -> rk_valid=0 next cycle, no done. Same-cycle flush+key_load -> no load. key_load while busy -> ignored.
- Async reset during round 10 -> all outputs 0 without a clock edge; a subsequent load runs normally.
- Parity (with KEY_PARITY_CHECK_EN): key 0x133457799BBCDFF0 -> parity_err pulse, load_ready stays 1, no rk_valid. 0x133457799BBCDFF1 accepted.
